// File: rtl/txn_prof_pkg.sv
// Shared defaults and record layouts for the ap_ctrl_hs transaction profiler.
package txn_prof_pkg;

    localparam int unsigned DEF_CNT_W = 32;
    localparam int unsigned DEF_ID_W  = 16;
    localparam int unsigned DEF_DEPTH = 8;

    // Record emitted per finished transaction (default widths).
    typedef struct packed {
        logic [DEF_ID_W-1:0]  id;
        logic [DEF_CNT_W-1:0] latency;
        logic [DEF_CNT_W-1:0] interval;
    } txn_rec_t;

    // In-flight entry captured at accept time (default widths).
    typedef struct packed {
        logic [DEF_ID_W-1:0]  id;
        logic [DEF_CNT_W-1:0] ts;
        logic [DEF_CNT_W-1:0] interval;
    } txn_entry_t;

endpackage

// File: rtl/txn_fifo.sv
// Synchronous FIFO; head word comes straight from storage flops, so a push is
// visible at the output the following cycle. Push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module txn_fifo
    import txn_prof_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Empty FIFO presents zeros so the output is defined straight out of reset.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage write; contents need no reset since occupancy gates the output.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ap_ctrl_txn_profiler.sv
// Observes an ap_ctrl_hs handshake, timestamps accepts and completions, and
// streams one {id, latency, interval} record per finished transaction.
module ap_ctrl_txn_profiler
    import txn_prof_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned ID_W  = DEF_ID_W,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [ID_W-1:0]  rec_id,
    output logic [CNT_W-1:0] rec_latency,
    output logic [CNT_W-1:0] rec_interval,
    output logic [ID_W-1:0]  txn_count,
    output logic             overflow,
    output logic             orphan_done
);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] latency;
        logic [CNT_W-1:0] interval;
    } rec_t;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] ts;
        logic [CNT_W-1:0] interval;
    } entry_t;

    logic [CNT_W-1:0] now;
    logic [CNT_W-1:0] prev_ts;
    logic             seen_accept;
    logic [CNT_W-1:0] cur_interval;

    logic   acc;
    logic   dne;
    logic   bypass;

    entry_t if_wdata;
    entry_t if_rdata;
    logic   if_push;
    logic   if_pop;
    logic   if_full;
    logic   if_empty;

    rec_t   rec_wdata;
    rec_t   rec_rdata;
    logic   rec_push;
    logic   rec_full;
    logic   rec_empty;

    logic   drop_accept;
    logic   drop_record;
    logic   orphan_evt;

    // Event decode and record assembly.
    always_comb begin
        acc          = ap_start & ap_ready;
        dne          = ap_done & ap_continue;
        cur_interval = seen_accept ? (now - prev_ts) : '0;
        // Accept and done together with nothing outstanding: the accept
        // completes on the spot and never occupies the in-flight queue.
        bypass       = acc & dne & if_empty;
        if_push      = acc & ~bypass;
        if_pop       = dne & ~if_empty;
        rec_push     = dne & (~if_empty | acc);

        if_wdata          = '0;
        if_wdata.id       = txn_count;
        if_wdata.ts       = now;
        if_wdata.interval = cur_interval;

        rec_wdata = '0;
        if (bypass) begin
            rec_wdata.id       = txn_count;
            rec_wdata.latency  = '0;
            rec_wdata.interval = cur_interval;
        end else begin
            rec_wdata.id       = if_rdata.id;
            rec_wdata.latency  = now - if_rdata.ts;
            rec_wdata.interval = if_rdata.interval;
        end

        drop_accept = if_push & if_full & ~dne;
        drop_record = rec_push & rec_full & ~(rec_valid & rec_ready);
        orphan_evt  = dne & if_empty & ~acc;
    end

    // Cycle counter, accept bookkeeping and sticky status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            now         <= '0;
            prev_ts     <= '0;
            seen_accept <= 1'b0;
            txn_count   <= '0;
            overflow    <= 1'b0;
            orphan_done <= 1'b0;
        end else begin
            now <= now + 1'b1;
            if (acc) begin
                prev_ts     <= now;
                seen_accept <= 1'b1;
                txn_count   <= txn_count + 1'b1;
            end
            if (drop_accept | drop_record) overflow    <= 1'b1;
            if (orphan_evt)                orphan_done <= 1'b1;
        end
    end

    txn_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_inflight (
        .clock (clock),
        .reset (reset),
        .push  (if_push),
        .wdata (if_wdata),
        .pop   (if_pop),
        .rdata (if_rdata),
        .full  (if_full),
        .empty (if_empty)
    );

    txn_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_records (
        .clock (clock),
        .reset (reset),
        .push  (rec_push),
        .wdata (rec_wdata),
        .pop   (rec_ready),
        .rdata (rec_rdata),
        .full  (rec_full),
        .empty (rec_empty)
    );

    assign rec_valid    = ~rec_empty;
    assign rec_id       = rec_rdata.id;
    assign rec_latency  = rec_rdata.latency;
    assign rec_interval = rec_rdata.interval;

endmodule

// File: doc/ap_ctrl_txn_profiler.md
# ap_ctrl_txn_profiler

Synthesizable per-transaction profiler placed directly downstream of an HLS kernel's ap_ctrl_hs block-level handshake. It observes ap_start/ap_ready/ap_done/ap_continue, timestamps every accepted start and every completion, and emits one record per finished transaction: id, latency, initiation interval. Records are buffered and drained over a valid/ready stream, so module-status profiling is available on silicon as well as in simulation.

## Interface
- CNT_W, 32: width of the cycle counter, latency and interval fields.
- ID_W, 16: width of the transaction id.
- DEPTH, 8: entries in the in-flight queue and the record FIFO (power of two, ≥2).
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset); deassertion is synchronous to clock.
- ap_start  in  1  kernel start, observed only.
- ap_ready  in  1  kernel input-accept, observed only.
- ap_done  in  1  kernel completion, observed only.
- ap_continue  in  1  downstream continue, observed only (tie 1 if unused).
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts record.
- rec_id  out  ID_W  transaction id (accept order, from 0).
- rec_latency  out  CNT_W  done cycle minus accept cycle.
- rec_interval  out  CNT_W  accept cycle minus previous accept cycle; 0 for first.
- txn_count  out  ID_W  number of accepted starts.
- overflow  out  1  sticky: an accept or a record was dropped.
- orphan_done  out  1  sticky: done with no outstanding accept.

## Operation
- Free-running cycle counter `now`, reset 0, wraps modulo 2^CNT_W; all subtractions modulo 2^CNT_W.
- Accept event A = ap_start & ap_ready. On A: push {id=txn_count, ts=now, interval} into in-flight queue; txn_count++ (wraps); prev_ts ← now. Interval = now − prev_ts, forced 0 for first accept after reset.
- Done event D = ap_done & ap_continue. On D: pop oldest in-flight entry; record = {id, now − ts, interval}; push to record FIFO.
- A and D in same cycle, in-flight queue empty: bypass, record latency 0 from the new accept; queue unchanged.
- A and D in same cycle, queue non-empty: pop oldest, push new; legal even when full.
- A with in-flight queue full and no D: entry dropped, overflow ← 1, txn_count still increments.
- D with queue empty and no A: no record, orphan_done ← 1.
- Record FIFO full on push: record dropped, overflow ← 1, unless rec_valid & rec_ready same cycle (pop frees slot, push accepted).
- Stream: rec_* stable while rec_valid & !rec_ready; transfer on rec_valid & rec_ready.

## Timing
- Reset values: rec_valid 0, rec_id/rec_latency/rec_interval 0, txn_count 0, overflow 0, orphan_done 0, now 0, both queues empty.
- Record visible on rec_valid the cycle after D (one register stage, FIFO output registered).
- txn_count updates the cycle after A. Sticky flags set the cycle after the causing event; cleared only by reset.
- Full-throughput: one A and one D per cycle sustained with no drops while rec_ready = 1.
- Reset mid-transaction: all in-flight state discarded immediately; a later D is orphan.

## Structure
- Package txn_prof_pkg: record struct {id, latency, interval}, in-flight entry struct {id, ts, interval}, parameter defaults.
- One sub-module txn_fifo (parameterised width/depth, sync, registered output, full/empty, simultaneous push/pop when full allowed), instantiated twice: in-flight queue and record FIFO.

## Test plan
- Single txn: A at cycle 10, D at cycle 15, rec_ready=1 → rec_valid at cycle 16, id 0, latency 5, interval 0; txn_count=1.
- Pipelined: A at 10,12,14; D at 20,22,24 → latencies 10,10,10; intervals 0,2,2; ids 0,1,2 in order.
- Same-cycle A+D, queue empty, cycle 7 → one record latency 0; queue remains empty; no flags.
- rec_ready=0, DEPTH=8, 9 complete txns → 8 held, overflow=1, txn_count=9; drain yields ids 0..7.
- D with nothing outstanding → orphan_done=1, rec_valid stays 0; CNT_W=8, A at now=250, D at now=4 → latency 10.
- reset low while 3 txns in flight → all outputs to reset values; following D sets orphan_done only.
